tiled_matvec_seq: RTL

- Sequential, tiled matrix-vector multiply engine computing y = A·x over unsigned DW-bit elements.
- Processes one BxB tile of A per clock, accumulating partial sums into per-row accumulators.
- Optional accumulate mode (y += A·x) for chained or blocked multi-pass use.
- Sits in the datapath as a multi-cycle compute unit driven by a start/done handshake.

---
 rtl/tiled_matvec_pkg.sv | 29 ++
 rtl/tiled_matvec_tile_mac.sv | 39 +++
 rtl/tiled_matvec_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tiled_matvec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tiled_matvec_pkg
// Description : Shared types and sizing helpers for the tiled mat-vec engine.
// Revision    : 1.0 - initial release
// ============================================================================
package tiled_matvec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 16;
    localparam int B_DEFAULT = 4;
    localparam int NT        = N_DEFAULT / B_DEFAULT;

    // Wide enough for a full N-term dot product of DW-bit operands.
    function automatic int calc_aw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int calc_nt(input int n, input int b);
        return n / b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tiled_matvec_tile_mac.sv
`default_nettype none
// ============================================================================
// Module      : tiled_matvec_tile_mac
// Description : Combinational BxB tile multiply-accumulate onto B row sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tiled_matvec_tile_mac
    import tiled_matvec_pkg::*;
#(
    parameter int B  = 4,
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic [B*B*DW-1:0] a_tile,
    input  logic [B*DW-1:0]   x_tile,
    input  logic [B*AW-1:0]   acc_in,
    output logic [B*AW-1:0]   acc_out
);

    logic [AW-1:0]   w_sum;
    logic [2*DW-1:0] w_prod;

    // Sums wrap modulo 2^AW by construction of the AW-bit adder chain.
    always_comb begin
        acc_out = '0;
        w_sum   = '0;
        w_prod  = '0;
        for (int r = 0; r < B; r++) begin
            w_sum = acc_in[r*AW +: AW];
            for (int c = 0; c < B; c++) begin
                w_prod = (2*DW)'(a_tile[(r*B+c)*DW +: DW]) * (2*DW)'(x_tile[c*DW +: DW]);
                w_sum  = w_sum + AW'(w_prod);
            end
            acc_out[r*AW +: AW] = w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tiled_matvec_seq.sv
`default_nettype none
// ============================================================================
// Module      : tiled_matvec_seq
// Description : Sequential y = A*x (or y += A*x), one BxB tile per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tiled_matvec_seq
    import tiled_matvec_pkg::*;
#(
    parameter int N  = 16,
    parameter int B  = 4,
    parameter int DW = 8,
    parameter int AW = calc_aw(DW, N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acc_mode,
    input  logic [N*DW-1:0]   x_in,
    input  logic [N*N*DW-1:0] a_in,
    output logic              busy,
    output logic              done,
    output logic [N*AW-1:0]   y_out
);

    localparam int c_tiles = calc_nt(N, B);
    localparam int c_tcw   = (c_tiles > 1) ? $clog2(c_tiles) : 1;
    localparam logic [c_tcw-1:0] c_tlast = c_tcw'(c_tiles - 1);

    if (N % B != 0) begin : g_param_check
        $error("tiled_matvec_seq: N must be a multiple of B");
    end

    state_t              r_state;
    state_t              w_state_next;
    logic [c_tcw-1:0]    r_ii;
    logic [c_tcw-1:0]    r_jj;
    logic [N*N*DW-1:0]   r_a;
    logic [N*DW-1:0]     r_x;
    logic [N*AW-1:0]     r_acc;
    logic [N*AW-1:0]     r_y;
    logic                w_last_tile;
    logic [31:0]         w_row0;
    logic [31:0]         w_col0;
    logic [B*B*DW-1:0]   w_a_tile;
    logic [B*DW-1:0]     w_x_tile;
    logic [B*AW-1:0]     w_acc_tile;
    logic [B*AW-1:0]     w_acc_upd;
    logic [N*AW-1:0]     w_acc_next;

    assign w_last_tile = (r_ii == c_tlast) && (r_jj == c_tlast);
    assign w_row0      = 32'(r_ii) * 32'(B);
    assign w_col0      = 32'(r_jj) * 32'(B);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last_tile) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------- tile gather
    always_comb begin
        w_a_tile   = '0;
        w_x_tile   = '0;
        w_acc_tile = '0;
        for (int bi = 0; bi < B; bi++) begin
            w_x_tile[bi*DW +: DW]   = r_x[(w_col0 + 32'(bi))*DW +: DW];
            w_acc_tile[bi*AW +: AW] = r_acc[(w_row0 + 32'(bi))*AW +: AW];
            for (int bj = 0; bj < B; bj++) begin
                w_a_tile[(bi*B+bj)*DW +: DW] =
                    r_a[((w_row0 + 32'(bi))*N + w_col0 + 32'(bj))*DW +: DW];
            end
        end
    end

    tiled_matvec_tile_mac #(
        .B  (B),
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .a_tile  (w_a_tile),
        .x_tile  (w_x_tile),
        .acc_in  (w_acc_tile),
        .acc_out (w_acc_upd)
    );

    // Only the B rows of the current tile change; the rest pass through.
    always_comb begin
        w_acc_next = r_acc;
        for (int bi = 0; bi < B; bi++) begin
            w_acc_next[(w_row0 + 32'(bi))*AW +: AW] = w_acc_upd[bi*AW +: AW];
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_x   <= '0;
            r_acc <= '0;
            r_y   <= '0;
            r_ii  <= '0;
            r_jj  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a  <= a_in;
                        r_x  <= x_in;
                        r_ii <= '0;
                        r_jj <= '0;
                        if (!acc_mode) begin
                            r_acc <= '0;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    if (r_jj == c_tlast) begin
                        r_jj <= '0;
                        r_ii <= r_ii + 1'b1;
                    end else begin
                        r_jj <= r_jj + 1'b1;
                    end
                    if (w_last_tile) begin
                        r_ii <= '0;
                        r_y  <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y_out = r_y;

endmodule
`default_nettype wire
